resonance_sweep_ctrl: RTL and testbench
=======================================

// Module: resonance_sweep_ctrl
// PURPOSE
//  Sequencer for the series-RLC resonance bench (Vac source -> R_par -> L -> C, probe at C node).
//  Steps the source frequency word over N_PTS points for each of N_RSEL R_par settings.
//  At each point it loads the DDS, waits a settle time and takes one magnitude sample.
//  Reports the peak (resonance) frequency word and its magnitude per R_par setting.
// PARAMETERS
//  FW       32    frequency-word width (DDS tuning word)
//  MW       16    magnitude sample width (unsigned)
//  PTW      10    point-counter width; N_PTS <= 2**PTW
//  RSW      3     R_par select width
//  SETTLE_W 16    settle-counter width
// PORTS
//  clk         in   1         rising-edge clock
//  rst         in   1         asynchronous active-high reset
//  start       in   1         pulse: begin sweep (ignored unless IDLE)
//  abort       in   1         pulse: stop sweep, go IDLE, no report for current setting
//  f_start     in   FW        first frequency word (sampled on start)
//  f_step      in   FW        per-point increment (sampled on start)
//  n_pts       in   PTW       points per sweep minus 1 (0 => one point)
//  n_rsel      in   RSW       R_par settings minus 1
//  settle_cyc  in   SETTLE_W  settle cycles after each load (0 allowed)
//  dds_freq    out  FW        frequency word to source
//  dds_load    out  1         one-cycle strobe: dds_freq valid
//  r_sel       out  RSW       active R_par setting
//  adc_req     out  1         sample request, held until adc_ack
//  adc_ack     in   1         sample accepted; adc_mag valid same cycle
//  adc_mag     in   MW        magnitude at probe node
//  res_valid   out  1         result valid, held until res_ready
//  res_ready   in   1         downstream accepts result
//  res_rsel    out  RSW       R_par setting of result
//  res_freq    out  FW        frequency word at peak
//  res_mag     out  MW        peak magnitude
//  busy        out  1         high in every state except IDLE
//  done        out  1         one-cycle pulse after final result accepted
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters, peak registers and latched config cleared.
//  IDLE -> LOAD on start: latch config, r_sel=0, pt=0, dds_freq=f_start, peak_mag=0, peak_vld=0.
//  LOAD (1 cycle): dds_load=1; settle counter := settle_cyc; -> SETTLE.
//  SETTLE: decrement each cycle; -> SAMPLE when count==0 (settle_cyc=0 => SAMPLE next cycle).
//  SAMPLE: adc_req=1 until adc_ack; on ack: if !peak_vld or adc_mag > peak_mag, capture
//    (dds_freq, adc_mag), set peak_vld. Ties keep the earlier (lower-index) point. -> NEXT.
//  NEXT: if pt==n_pts -> REPORT; else pt++, dds_freq += f_step (mod 2**FW, wraps silently) -> LOAD.
//  REPORT: res_valid=1, res_* stable until res_ready. On handshake: if r_sel==n_rsel -> IDLE
//    and done pulses the same cycle; else r_sel++, pt=0, dds_freq=f_start, peak cleared -> LOAD.
//  Latency per point = 1 (LOAD) + settle_cyc + 1 + ADC wait + 1 (NEXT) cycles.
//  adc_ack outside SAMPLE: ignored. res_ready outside REPORT: ignored.
//  abort (any non-IDLE state) wins over all same-cycle events: adc_req, res_valid drop next cycle;
//    -> IDLE, no done pulse. start in the same cycle as abort is ignored.
//  start while busy: ignored; latched config is unchanged mid-sweep.
//  Async rst mid-sweep: immediate return to reset values; no partial result survives.
// STRUCTURE
//  resonance_pkg: state enum (IDLE, LOAD, SETTLE, SAMPLE, NEXT, REPORT), default widths.
//  Sub-module peak_tracker (clear, sample strobe, freq, mag -> peak_freq, peak_mag, peak_vld).
//  Top holds FSM, point/R counters, settle counter, frequency accumulator.
// TESTING
//  1 f_start=100,f_step=10,n_pts=4,n_rsel=0,settle=2, mags 5,9,20,7,3 -> one result freq=120,
//    mag=20, rsel=0; done pulse; dds_load x5 with words 100..140.
//  2 n_rsel=2, n_pts=2, peaks at points 1/0/2 -> three results rsel 0,1,2 in order; r_sel tracks.
//  3 tie: mags 8,8,8 -> res_freq=f_start; settle=0 -> SAMPLE one cycle after each dds_load.
//  4 f_start=2**32-5,f_step=4,n_pts=2 -> words 0xFFFFFFFB,0xFFFFFFFF,0x00000003.
//  5 res_ready low 10 cycles -> res_* stable, no new dds_load; adc_ack delayed 7 cycles -> req held.
//  6 abort during SAMPLE, and rst during SETTLE -> IDLE, all outputs 0, no done; restart succeeds.

Source files
------------

// File: rtl/resonance_pkg.sv
// Shared widths and FSM state encoding for the RLC resonance sweep sequencer.
package resonance_pkg;
  localparam int FW_D       = 32;
  localparam int MW_D       = 16;
  localparam int PTW_D      = 10;
  localparam int RSW_D      = 3;
  localparam int SETTLE_W_D = 16;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD   = 3'd1;
  localparam state_t S_SETTLE = 3'd2;
  localparam state_t S_SAMPLE = 3'd3;
  localparam state_t S_NEXT   = 3'd4;
  localparam state_t S_REPORT = 3'd5;
endpackage

// File: rtl/resonance_peak_tracker.sv
// Running maximum of magnitude samples with the frequency word at which it occurred.
module peak_tracker #(
  parameter int FW = 32,
  parameter int MW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          sample,
  input  logic [FW-1:0] freq,
  input  logic [MW-1:0] mag,
  output logic [FW-1:0] peak_freq,
  output logic [MW-1:0] peak_mag,
  output logic          peak_vld
);
  // Strict '>' keeps the earliest point on ties; first sample always captures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_freq <= '0;
      peak_mag  <= '0;
      peak_vld  <= 1'b0;
    end else if (clear) begin
      peak_freq <= '0;
      peak_mag  <= '0;
      peak_vld  <= 1'b0;
    end else if (sample && (!peak_vld || mag > peak_mag)) begin
      peak_freq <= freq;
      peak_mag  <= mag;
      peak_vld  <= 1'b1;
    end
  end
endmodule

// File: rtl/resonance_sweep_ctrl.sv
// Frequency sweep sequencer: per R_par setting, step the DDS, settle, sample, report the peak.
module resonance_sweep_ctrl
  import resonance_pkg::*;
#(
  parameter int FW       = FW_D,
  parameter int MW       = MW_D,
  parameter int PTW      = PTW_D,
  parameter int RSW      = RSW_D,
  parameter int SETTLE_W = SETTLE_W_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [FW-1:0]       f_start,
  input  logic [FW-1:0]       f_step,
  input  logic [PTW-1:0]      n_pts,
  input  logic [RSW-1:0]      n_rsel,
  input  logic [SETTLE_W-1:0] settle_cyc,
  output logic [FW-1:0]       dds_freq,
  output logic                dds_load,
  output logic [RSW-1:0]      r_sel,
  output logic                adc_req,
  input  logic                adc_ack,
  input  logic [MW-1:0]       adc_mag,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RSW-1:0]      res_rsel,
  output logic [FW-1:0]       res_freq,
  output logic [MW-1:0]       res_mag,
  output logic                busy,
  output logic                done
);
  state_t              state;
  logic [FW-1:0]       cfg_f_start, cfg_f_step;
  logic [PTW-1:0]      cfg_n_pts, pt;
  logic [RSW-1:0]      cfg_n_rsel;
  logic [SETTLE_W-1:0] cfg_settle, settle_cnt;
  logic                peak_vld;

  logic abort_act, rpt_hs, last_r, smp, pk_clr;
  assign abort_act = abort && (state != S_IDLE);
  assign rpt_hs    = (state == S_REPORT) && res_ready && !abort;
  assign last_r    = (r_sel == cfg_n_rsel);
  assign smp       = (state == S_SAMPLE) && adc_ack && !abort;
  assign pk_clr    = abort_act || ((state == S_IDLE) && start) || rpt_hs;

  assign dds_load  = (state == S_LOAD);
  assign adc_req   = (state == S_SAMPLE);
  assign res_valid = (state == S_REPORT);
  assign busy      = (state != S_IDLE);
  assign done      = rpt_hs && last_r;
  assign res_rsel  = r_sel;

  peak_tracker #(.FW(FW), .MW(MW)) u_peak (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clr),
    .sample    (smp),
    .freq      (dds_freq),
    .mag       (adc_mag),
    .peak_freq (res_freq),
    .peak_mag  (res_mag),
    .peak_vld  (peak_vld)
  );

  // Every return to IDLE zeroes the sweep registers so an idle block shows all-zero outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cfg_f_start <= '0;
      cfg_f_step  <= '0;
      cfg_n_pts   <= '0;
      cfg_n_rsel  <= '0;
      cfg_settle  <= '0;
      pt          <= '0;
      r_sel       <= '0;
      dds_freq    <= '0;
      settle_cnt  <= '0;
    end else if (abort_act) begin
      state      <= S_IDLE;
      pt         <= '0;
      r_sel      <= '0;
      dds_freq   <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cfg_f_start <= f_start;
          cfg_f_step  <= f_step;
          cfg_n_pts   <= n_pts;
          cfg_n_rsel  <= n_rsel;
          cfg_settle  <= settle_cyc;
          pt          <= '0;
          r_sel       <= '0;
          dds_freq    <= f_start;
          state       <= S_LOAD;
        end
        S_LOAD: begin
          settle_cnt <= cfg_settle;
          state      <= (cfg_settle == '0) ? S_SAMPLE : S_SETTLE;
        end
        // SETTLE lasts exactly cfg_settle cycles: leave as the count reaches zero.
        S_SETTLE: begin
          settle_cnt <= settle_cnt - SETTLE_W'(1);
          if (settle_cnt <= SETTLE_W'(1)) state <= S_SAMPLE;
        end
        S_SAMPLE: if (adc_ack) state <= S_NEXT;
        S_NEXT: begin
          if (pt == cfg_n_pts) begin
            state <= S_REPORT;
          end else begin
            pt       <= pt + PTW'(1);
            dds_freq <= dds_freq + cfg_f_step;
            state    <= S_LOAD;
          end
        end
        S_REPORT: if (res_ready) begin
          pt <= '0;
          if (last_r) begin
            r_sel    <= '0;
            dds_freq <= '0;
            state    <= S_IDLE;
          end else begin
            r_sel    <= r_sel + RSW'(1);
            dds_freq <= cfg_f_start;
            state    <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_resonance_sweep_ctrl.sv
// Directed bench: table of sweep vectors with hand-computed peaks, plus abort/reset sequences.
module tb_resonance_sweep_ctrl;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [31:0] f_start = '0, f_step = '0;
  logic [9:0]  n_pts = '0;
  logic [2:0]  n_rsel = '0;
  logic [15:0] settle_cyc = '0;
  logic [31:0] dds_freq, res_freq;
  logic        dds_load, adc_req, res_valid, busy, done;
  logic        adc_ack = 1'b0, res_ready = 1'b0;
  logic [15:0] adc_mag = '0, res_mag;
  logic [2:0]  r_sel, res_rsel;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  resonance_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_pts(n_pts), .n_rsel(n_rsel),
    .settle_cyc(settle_cyc), .dds_freq(dds_freq), .dds_load(dds_load), .r_sel(r_sel),
    .adc_req(adc_req), .adc_ack(adc_ack), .adc_mag(adc_mag),
    .res_valid(res_valid), .res_ready(res_ready), .res_rsel(res_rsel),
    .res_freq(res_freq), .res_mag(res_mag), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [31:0]       f_start, f_step;
    logic [9:0]        n_pts;
    logic [2:0]        n_rsel;
    logic [15:0]       settle, ack_dly, rdy_dly;
    logic [8:0][15:0]  mags;
    logic [2:0][31:0]  e_freq;
    logic [2:0][15:0]  e_mag;
  } vec_t;

  vec_t tab[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dds_load"}, dds_load, 0);
    chk({tag, "_dds_freq"}, dds_freq, 0);
    chk({tag, "_r_sel"}, r_sel, 0);
    chk({tag, "_adc_req"}, adc_req, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_rsel"}, res_rsel, 0);
    chk({tag, "_res_freq"}, res_freq, 0);
    chk({tag, "_res_mag"}, res_mag, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  function automatic vec_t mk(input logic [31:0] fs, input logic [31:0] st, input logic [9:0] np,
                              input logic [2:0] nr, input logic [15:0] se, input logic [15:0] ad,
                              input logic [15:0] rd);
    vec_t v;
    v = '0;
    v.f_start = fs; v.f_step = st; v.n_pts = np; v.n_rsel = nr;
    v.settle = se; v.ack_dly = ad; v.rdy_dly = rd;
    return v;
  endfunction

  // Drives one full sweep, acting as ADC and result sink; garbles config ports after start.
  task automatic run_vec(input vec_t v);
    int lp, rs, idx, nld, nres, wait_c, rdy_c, load_cyc, cyc;
    bit pend, fin;
    logic [31:0] ef;
    lp = 0; rs = 0; idx = 0; nld = 0; nres = 0; wait_c = 0; rdy_c = 0;
    load_cyc = 0; cyc = 0; pend = 0; fin = 0;
    f_start = v.f_start; f_step = v.f_step; n_pts = v.n_pts; n_rsel = v.n_rsel;
    settle_cyc = v.settle; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    f_start = 32'hDEAD_BEEF; f_step = 32'h1234_5678; n_pts = '1; n_rsel = '1; settle_cyc = '1;
    while (!fin && cyc < 2000) begin
      adc_ack = 1'b0; res_ready = 1'b0; start = (cyc == 3);
      if (dds_load) begin
        ef = v.f_start + 32'(lp) * v.f_step;
        chk("dds_freq", dds_freq, ef);
        chk("r_sel", r_sel, rs);
        load_cyc = cyc; lp++; nld++;
      end
      if (pend) chk("adc_req_held", adc_req, 1);
      if (adc_req) begin
        if (!pend) begin
          chk("settle_latency", cyc - load_cyc, v.settle + 1);
          pend = 1; wait_c = 0;
        end
        if (wait_c == v.ack_dly) begin
          adc_ack = 1'b1;
          adc_mag = (idx < 9) ? v.mags[idx] : 16'h0;
          idx++; pend = 0;
        end
        wait_c++;
      end
      if (res_valid) begin
        chk("res_rsel", res_rsel, rs);
        chk("res_freq", res_freq, v.e_freq[rs]);
        chk("res_mag", res_mag, v.e_mag[rs]);
        if (rdy_c == v.rdy_dly) begin
          res_ready = 1'b1;
          #1;
          chk("done", done, rs == v.n_rsel);
          if (rs == v.n_rsel) fin = 1;
          rs++; lp = 0; rdy_c = 0; nres++;
        end else begin
          rdy_c++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; adc_ack = 1'b0; res_ready = 1'b0;
    if (!fin) chk("sweep_timeout", 0, 1);
    chk("load_count", nld, (v.n_pts + 1) * (v.n_rsel + 1));
    chk("result_count", nres, v.n_rsel + 1);
    chk("end_busy", busy, 0);
    chk("end_res_valid", res_valid, 0);
  endtask

  initial begin
    tab[0] = mk(100, 10, 4, 0, 2, 0, 0);
    tab[0].mags[4:0] = {16'd3, 16'd7, 16'd20, 16'd9, 16'd5};
    tab[0].e_freq[0] = 120; tab[0].e_mag[0] = 20;

    tab[1] = mk(1000, 50, 2, 2, 1, 0, 0);
    tab[1].mags = {16'd30, 16'd2, 16'd1, 16'd11, 16'd5, 16'd12, 16'd4, 16'd9, 16'd3};
    tab[1].e_freq = {32'd1100, 32'd1000, 32'd1050};
    tab[1].e_mag  = {16'd30, 16'd12, 16'd9};

    tab[2] = mk(500, 7, 2, 0, 0, 0, 0);
    tab[2].mags[2:0] = {16'd8, 16'd8, 16'd8};
    tab[2].e_freq[0] = 500; tab[2].e_mag[0] = 8;

    tab[3] = mk(32'hFFFF_FFFB, 4, 2, 0, 1, 0, 0);
    tab[3].mags[2:0] = {16'd3, 16'd2, 16'd1};
    tab[3].e_freq[0] = 32'h0000_0003; tab[3].e_mag[0] = 3;

    tab[4] = mk(10, 1, 1, 0, 3, 7, 10);
    tab[4].mags[1:0] = {16'd6, 16'd4};
    tab[4].e_freq[0] = 11; tab[4].e_mag[0] = 6;

    tab[5] = mk(77, 3, 1, 0, 1, 0, 0);
    tab[5].e_freq[0] = 77; tab[5].e_mag[0] = 0;

    tab[6] = mk(42, 9, 0, 1, 0, 2, 1);
    tab[6].mags[1:0] = {16'd6, 16'd5};
    tab[6].e_freq = {32'd0, 32'd42, 32'd42};
    tab[6].e_mag  = {16'd0, 16'd6, 16'd5};

    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    for (int i = 0; i < 7; i++) run_vec(tab[i]);

    // Abort in SAMPLE with a simultaneous ack and start: abort must win.
    f_start = 100; f_step = 10; n_pts = 4; n_rsel = 0; settle_cyc = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !adc_req; i++) @(negedge clk);
    chk("abort_reach_sample", adc_req, 1);
    abort = 1'b1; adc_ack = 1'b1; adc_mag = 16'hFFFF; start = 1'b1;
    #1 chk("abort_no_done", done, 0);
    @(negedge clk);
    abort = 1'b0; adc_ack = 1'b0; start = 1'b0;
    chk_idle("abort");
    @(negedge clk);
    chk("abort_stays_idle", busy, 0);
    run_vec(tab[0]);

    // Asynchronous reset in the middle of SETTLE.
    f_start = 300; f_step = 5; n_pts = 3; n_rsel = 1; settle_cyc = 20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_seq_load", dds_load, 1);
    repeat (3) @(negedge clk);
    chk("rst_seq_busy", busy, 1);
    #2 rst = 1'b1;
    #1 chk_idle("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("after_rst");
    run_vec(tab[1]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
